// File: rtl/flick_if.sv
// Flick button conditioner signal bundle: raw button in, debounced level, strobes and status out.
// dbg_state encoding: 0=LOW, 1=CHK_HI, 2=HIGH, 3=CHK_LO.
interface flick_if;
   logic       flick_raw;
   logic       flick;
   logic       flick_rise;
   logic       flick_fall;
   logic       busy;
   logic [1:0] dbg_state;

   // Handshake: level-only, no valid/ready; flick_rise/flick_fall are single-cycle
   // strobes that always coincide with the matching change of flick.
   modport master (
      output flick_raw,
      input  flick, flick_rise, flick_fall, busy, dbg_state
   );

   modport slave (
      input  flick_raw,
      output flick, flick_rise, flick_fall, busy, dbg_state
   );
endinterface

// File: rtl/flick_conditioner.sv
// Synchronises and debounces the raw flick button; a new level is accepted only after
// STABLE_CYCLES consecutive synchronised samples agree, with 1-cycle edge strobes.
module flick_conditioner #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 3
) (
   input  logic   clk,
   input  logic   rst,
   flick_if.slave fc
);

   typedef enum logic [1:0] {
      ST_LOW    = 2'd0,
      ST_CHK_HI = 2'd1,
      ST_HIGH   = 2'd2,
      ST_CHK_LO = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             sync1_q;
   logic             sync_q;
   logic             flick_q;
   logic             rise_q;
   logic             fall_q;
   logic             busy_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync_q  <= 1'b0;
         state_q <= ST_LOW;
         cnt_q   <= '0;
         flick_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         sync1_q <= fc.flick_raw;
         sync_q  <= sync1_q;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         case (state_q)
            ST_LOW: begin
               if (sync_q) begin
                  state_q <= ST_CHK_HI;
                  cnt_q   <= CNT_ONE;
                  busy_q  <= 1'b1;
               end
            end
            ST_CHK_HI: begin
               if (!sync_q) begin
                  state_q <= ST_LOW;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= ST_HIGH;
                  cnt_q   <= '0;
                  flick_q <= 1'b1;
                  rise_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            ST_HIGH: begin
               if (!sync_q) begin
                  state_q <= ST_CHK_LO;
                  cnt_q   <= CNT_ONE;
                  busy_q  <= 1'b1;
               end
            end
            ST_CHK_LO: begin
               // A bounce back to 1 returns to HIGH without ever touching flick.
               if (sync_q) begin
                  state_q <= ST_HIGH;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= ST_LOW;
                  cnt_q   <= '0;
                  flick_q <= 1'b0;
                  fall_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_q <= ST_LOW;
               cnt_q   <= '0;
               flick_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign fc.flick      = flick_q;
   assign fc.flick_rise = rise_q;
   assign fc.flick_fall = fall_q;
   assign fc.busy       = busy_q;
   assign fc.dbg_state  = state_q;

endmodule

// File: tb/tb_flick_conditioner.sv
// Directed plus randomized bench for flick_conditioner against a run-length reference model.
module tb_flick_conditioner;

   localparam int STABLE = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   flick_if bus ();

   flick_conditioner #(.STABLE_CYCLES(STABLE), .CNT_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .fc  (bus)
   );

   // Reference: raw seen by the debouncer two edges late; the level flips once
   // STABLE consecutive samples disagree with it, any agreeing sample clears the run.
   logic       hist[$];
   logic       m_level;
   int         m_run;
   logic       m_rise;
   logic       m_fall;
   int         rise_seen;
   int         fall_seen;
   int         busy_seen;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic raw_v, input logic rst_v);
      logic s;
      logic [1:0] exp_state;
      @(negedge clk);
      bus.flick_raw = raw_v;
      rst = rst_v;
      @(posedge clk);
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (rst_v) begin
         hist    = '{1'b0, 1'b0};
         m_level = 1'b0;
         m_run   = 0;
      end else begin
         s = hist.pop_front();
         hist.push_back(raw_v);
         if (s != m_level) begin
            m_run++;
            if (m_run == STABLE) begin
               m_level = ~m_level;
               m_run   = 0;
               m_rise  = m_level;
               m_fall  = ~m_level;
            end
         end else begin
            m_run = 0;
         end
      end
      #1;
      exp_state = m_level ? ((m_run != 0) ? 2'd3 : 2'd2) : ((m_run != 0) ? 2'd1 : 2'd0);
      check("flick", 8'(bus.flick), 8'(m_level));
      check("flick_rise", 8'(bus.flick_rise), 8'(m_rise));
      check("flick_fall", 8'(bus.flick_fall), 8'(m_fall));
      check("busy", 8'(bus.busy), 8'(m_run != 0));
      check("state", 8'(bus.dbg_state), 8'(exp_state));
      if (bus.flick_rise) rise_seen++;
      if (bus.flick_fall) fall_seen++;
      if (bus.busy) busy_seen++;
   endtask

   task automatic clear_tally();
      rise_seen = 0;
      fall_seen = 0;
      busy_seen = 0;
   endtask

   initial begin
      int k;
      logic lvl;
      int len;
      hist    = '{1'b0, 1'b0};
      m_level = 1'b0;
      m_run   = 0;
      bus.flick_raw = 1'b0;
      clear_tally();

      // 1: reset with raw held high, then full re-qualification after release
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      check("reset_flick", 8'(bus.flick), 8'd0);
      check("reset_busy", 8'(bus.busy), 8'd0);
      k = 0;
      while (k < 20 && !bus.flick) begin
         step(1'b1, 1'b0);
         k++;
      end
      check("reset_release_latency", 8'(k), 8'(STABLE + 2));
      check("reset_release_rise", 8'(bus.flick_rise), 8'd1);

      // back to LOW cleanly
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
      check("settled_low", 8'(bus.flick), 8'd0);

      // 2: clean press held 20 cycles, one rise at STABLE+2 edges
      clear_tally();
      k = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0);
         if (bus.flick_rise) k = i + 1;
      end
      check("press_rise_edge", 8'(k), 8'(STABLE + 2));
      check("press_rise_count", 8'(rise_seen), 8'd1);
      check("press_held", 8'(bus.flick), 8'd1);

      // 5: release, exactly one fall
      clear_tally();
      k = 0;
      for (int i = 0; i < 15; i++) begin
         step(1'b0, 1'b0);
         if (bus.flick_fall) k = i + 1;
      end
      check("release_fall_edge", 8'(k), 8'(STABLE + 2));
      check("release_fall_count", 8'(fall_seen), 8'd1);
      check("release_low", 8'(bus.flick), 8'd0);

      // 3: bounce then settle high
      clear_tally();
      for (int i = 0; i < 4; i++) step(1'(i % 2 == 0), 1'b0);
      check("bounce_no_rise", 8'(rise_seen), 8'd0);
      k = 0;
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 1'b0);
         if (bus.flick_rise && k == 0) k = i + 1;
      end
      check("bounce_rise_edge", 8'(k), 8'(STABLE + 2));
      check("bounce_rise_count", 8'(rise_seen), 8'd1);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0);

      // 4: 2-cycle glitch while LOW
      clear_tally();
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
      check("glitch_busy_cycles", 8'(busy_seen >= 2 && busy_seen <= 3), 8'd1);
      check("glitch_no_strobe", 8'(rise_seen + fall_seen), 8'd0);
      check("glitch_flick", 8'(bus.flick), 8'd0);

      // 6: reset while qualifying with cnt=2
      clear_tally();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
      check("midrst_pre_state", 8'(bus.dbg_state), 8'd1);
      step(1'b1, 1'b1);
      check("midrst_state", 8'(bus.dbg_state), 8'd0);
      check("midrst_busy", 8'(bus.busy), 8'd0);
      check("midrst_no_strobe", 8'(rise_seen + fall_seen), 8'd0);

      // randomized segments with occasional reset
      lvl = 1'b0;
      for (int seg = 0; seg < 120; seg++) begin
         lvl = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 8);
         for (int i = 0; i < len; i++) begin
            step(lvl, ($urandom_range(0, 59) == 0));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
